rf_2w2r_sb: RTL

Parametrised register file for the single-cycle/pipelined CPU datapath: two read ports, two write ports, one debug read port, same-cycle write-to-read bypass, and a per-register pending (scoreboard) bit for multi-cycle producers (loads, multiply/divide). It replaces the fixed 32x32, one-write-port register file. Control and hazard logic use it directly, without an external forwarding mux for the writeback stage.

---
 rtl/rf_2w2r_sb.sv | 110 +++++++++++
 1 files changed

// File: rtl/rf_2w2r_sb.sv
// ============================================================================
// Module      : rf_2w2r_sb
// Description : 2^AW x DW register file with two write ports, two bypassed
//               read ports, a debug read port and per-register pending bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_2w2r_sb #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we0,
    input  logic [AW-1:0] wa0,
    input  logic [DW-1:0] wd0,
    input  logic          we1,
    input  logic [AW-1:0] wa1,
    input  logic [DW-1:0] wd1,
    input  logic          claim,
    input  logic [AW-1:0] claim_a,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic          busy1,
    output logic          busy2,
    input  logic [AW-1:0] reg_sel,
    output logic [DW-1:0] reg_data,
    output logic          any_busy
);

    localparam int   c_DEPTH = 1 << AW;
    localparam logic c_ZERO  = (ZERO_REG != 0);

    logic [DW-1:0]    r_rf [c_DEPTH];
    logic [c_DEPTH-1:0] r_pend;

    logic w_wr0;
    logic w_wr1;
    logic w_claim;

    // Register 0 is hard-wired when c_ZERO: suppress every update aimed at it.
    assign w_wr0   = we0   && !(c_ZERO && (wa0     == '0));
    assign w_wr1   = we1   && !(c_ZERO && (wa1     == '0));
    assign w_claim = claim && !(c_ZERO && (claim_a == '0));

    // Port 1 is applied after port 0 so it wins a same-address collision;
    // likewise the claim is applied last so it overrides a clearing write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_rf[i] <= '0;
            end
            r_pend <= '0;
        end else begin
            if (w_wr0) begin
                r_rf[wa0]   <= wd0;
                r_pend[wa0] <= 1'b0;
            end
            if (w_wr1) begin
                r_rf[wa1]   <= wd1;
                r_pend[wa1] <= 1'b0;
            end
            if (w_claim) begin
                r_pend[claim_a] <= 1'b1;
            end
        end
    end

    logic [AW-1:0] w_ra   [2];
    logic [DW-1:0] w_rd   [2];
    logic          w_busy [2];

    assign w_ra[0] = ra1;
    assign w_ra[1] = ra2;

    generate
        for (genvar n = 0; n < 2; n++) begin : g_rd_port
            always_comb begin
                w_rd[n]   = r_rf[w_ra[n]];
                w_busy[n] = r_pend[w_ra[n]];
                if (c_ZERO && (w_ra[n] == '0)) begin
                    w_rd[n]   = '0;
                    w_busy[n] = 1'b0;
                end else if (we1 && (wa1 == w_ra[n])) begin
                    w_rd[n]   = wd1;
                    w_busy[n] = 1'b0;
                end else if (we0 && (wa0 == w_ra[n])) begin
                    w_rd[n]   = wd0;
                    w_busy[n] = 1'b0;
                end
            end
        end
    endgenerate

    assign rd1   = w_rd[0];
    assign rd2   = w_rd[1];
    assign busy1 = w_busy[0];
    assign busy2 = w_busy[1];

    // Debug view is array state only, deliberately without bypass.
    assign reg_data = (c_ZERO && (reg_sel == '0)) ? '0 : r_rf[reg_sel];
    assign any_busy = |r_pend;

endmodule

`default_nettype wire
